clk_period_meter: RTL and testbench

- Measures the period of a slow, square-wave input against the system clock and reports it as a cycle count.
- Performs the inverse of the team's divided-clock generators: given a divided clock, it recovers the divide count.
- A generator toggling every CNT cycles reads back as CNT in half-period mode and 2*CNT in full-period mode.
- Used for self-check of the display/scan clock path and for measuring external slow signals on the CPU lab board.

---
 rtl/clk_period_meter_if.sv | 31 +++
 rtl/clk_period_meter.sv | 144 ++++++++++++++
 tb/tb_clk_period_meter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if
//   Signal bundle between a clk_period_meter and its user.
//   master : drives the measured signal and the mode select, receives results.
//   slave  : the meter itself.
// Signals:
//   sig_in      slow asynchronous signal to be measured
//   full_mode   0 = any edge to any edge, 1 = rising edge to rising edge
//   cnt_out     last completed measurement in clk cycles (W bits)
//   meas_valid  one-cycle pulse when cnt_out is updated
//   locked      last LOCK_N measurements of the current run were identical
//   timeout     sticky flag, set when a measurement is abandoned
interface clk_period_meter_if #(
  parameter int W = 23
);
  logic         sig_in;
  logic         full_mode;
  logic [W-1:0] cnt_out;
  logic         meas_valid;
  logic         locked;
  logic         timeout;

  modport master (
    output sig_in, full_mode,
    input  cnt_out, meas_valid, locked, timeout
  );

  modport slave (
    input  sig_in, full_mode,
    output cnt_out, meas_valid, locked, timeout
  );
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures the period of a slow square wave in clk cycles. It recovers the
//   divide count of a divided clock: a generator toggling every CNT cycles
//   reads back as CNT in half-period mode and 2*CNT in full-period mode.
// Parameters:
//   W        width of the run counter and of cnt_out
//   TIMEOUT  run count at which a measurement is abandoned (<= 2^W-1)
//   LOCK_N   consecutive identical measurements needed for locked (2..15)
// Ports:
//   clk    system clock
//   reset  synchronous, active-low reset
//   bus    clk_period_meter_if slave modport (sig_in, full_mode in;
//          cnt_out, meas_valid, locked, timeout out)
module clk_period_meter #(
  parameter int W       = 23,
  parameter int TIMEOUT = 8388607,
  parameter int LOCK_N  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  clk_period_meter_if.slave       bus
);

  typedef enum logic {IDLE, MEAS} state_t;

  localparam logic [W-1:0] TIMEOUT_CNT = W'(TIMEOUT);
  localparam logic [3:0]   MATCH_MAX   = 4'(LOCK_N - 1);

  // Input conditioning: two synchronizer flops plus one delay flop.
  logic s0_reg, s1_reg, s1_d_reg;
  logic full_mode_reg;

  state_t       state_reg, state_next;
  logic [W-1:0] run_reg, run_next;
  logic [W-1:0] cnt_out_reg, cnt_out_next;
  logic         meas_valid_reg, meas_valid_next;
  logic         locked_reg, locked_next;
  logic         timeout_reg, timeout_next;
  logic [3:0]   match_reg, match_next;
  // Set once the current MEAS run has produced an update, so the first
  // measurement after IDLE can never count as a match.
  logic         have_prev_reg, have_prev_next;

  logic rise, fall, qual, mode_chg;

  assign rise     = s1_reg & ~s1_d_reg;
  assign fall     = ~s1_reg & s1_d_reg;
  assign qual     = full_mode_reg ? rise : (rise | fall);
  assign mode_chg = bus.full_mode != full_mode_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s0_reg         <= 1'b0;
      s1_reg         <= 1'b0;
      s1_d_reg       <= 1'b0;
      full_mode_reg  <= 1'b0;
      state_reg      <= IDLE;
      run_reg        <= '0;
      cnt_out_reg    <= '0;
      meas_valid_reg <= 1'b0;
      locked_reg     <= 1'b0;
      timeout_reg    <= 1'b0;
      match_reg      <= '0;
      have_prev_reg  <= 1'b0;
    end else begin
      s0_reg         <= bus.sig_in;
      s1_reg         <= s0_reg;
      s1_d_reg       <= s1_reg;
      full_mode_reg  <= bus.full_mode;
      state_reg      <= state_next;
      run_reg        <= run_next;
      cnt_out_reg    <= cnt_out_next;
      meas_valid_reg <= meas_valid_next;
      locked_reg     <= locked_next;
      timeout_reg    <= timeout_next;
      match_reg      <= match_next;
      have_prev_reg  <= have_prev_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    run_next        = run_reg;
    cnt_out_next    = cnt_out_reg;
    meas_valid_next = 1'b0;
    locked_next     = locked_reg;
    timeout_next    = timeout_reg;
    match_next      = match_reg;
    have_prev_next  = have_prev_reg;

    if (mode_chg) begin
      // A mode switch invalidates the run in progress; results are held.
      state_next     = IDLE;
      run_next       = '0;
      locked_next    = 1'b0;
      match_next     = '0;
      have_prev_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (qual) begin
            state_next     = MEAS;
            run_next       = W'(1);
            have_prev_next = 1'b0;
          end
        end
        MEAS: begin
          // The edge is checked first so it wins over a simultaneous timeout.
          if (qual) begin
            cnt_out_next    = run_reg;
            meas_valid_next = 1'b1;
            run_next        = W'(1);
            timeout_next    = 1'b0;
            have_prev_next  = 1'b1;
            if (have_prev_reg && (run_reg == cnt_out_reg)) begin
              if (match_reg != MATCH_MAX) begin
                match_next = match_reg + 4'd1;
              end
            end else begin
              match_next = '0;
            end
            locked_next = (match_next == MATCH_MAX);
          end else if (run_reg == TIMEOUT_CNT) begin
            state_next     = IDLE;
            run_next       = '0;
            timeout_next   = 1'b1;
            locked_next    = 1'b0;
            match_next     = '0;
            have_prev_next = 1'b0;
          end else begin
            run_next = run_reg + W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.cnt_out    = cnt_out_reg;
  assign bus.meas_valid = meas_valid_reg;
  assign bus.locked     = locked_reg;
  assign bus.timeout    = timeout_reg;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter
//   Self-checking bench for clk_period_meter: a table of toggle patterns,
//   directed corner sequences and randomized bursts, all compared every
//   cycle against an event-based reference model.
module tb_clk_period_meter;
  localparam int W       = 23;
  localparam int TIMEOUT = 64;
  localparam int LOCK_N  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  clk_period_meter_if #(.W(W)) bus();

  clk_period_meter #(.W(W), .TIMEOUT(TIMEOUT), .LOCK_N(LOCK_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  logic rst_s = 1'b0;
  logic fm_s  = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= reset;
    fm_s  <= bus.full_mode;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Each sig_in change becomes an edge event that the meter acts on three
  // clk edges after it is driven. Measurements are differences of event times.
  typedef struct {int due; bit rising;} ev_t;
  ev_t ev_q[$];
  bit  sig_level = 1'b0;
  int  last_tog  = 0;

  bit       m_run = 1'b0;
  int       m_last = 0;
  int       hist[$];
  bit       m_fm = 1'b0;
  logic [W-1:0] e_cnt = '0;
  bit       e_mv = 1'b0, e_lk = 1'b0, e_to = 1'b0;
  bit       ed, ed_rise, qual;
  int       mv_count = 0;
  bit       lk_seen  = 1'b0;

  function automatic bit lock_ok();
    if (hist.size() < LOCK_N) return 1'b0;
    for (int i = hist.size() - LOCK_N; i < hist.size(); i++)
      if (hist[i] != hist[hist.size() - 1]) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (cyc >= 1) begin
      e_mv = 1'b0;
      if (!rst_s) begin
        m_run = 1'b0; hist.delete(); ev_q.delete(); m_fm = 1'b0;
        e_cnt = '0; e_lk = 1'b0; e_to = 1'b0;
      end else begin
        ed = 1'b0; ed_rise = 1'b0;
        if (ev_q.size() > 0 && ev_q[0].due == cyc) begin
          ed = 1'b1; ed_rise = ev_q[0].rising; void'(ev_q.pop_front());
        end
        qual = ed && (!m_fm || ed_rise);
        if (fm_s != m_fm) begin
          m_run = 1'b0; hist.delete(); e_lk = 1'b0;
        end else if (m_run) begin
          if (qual) begin
            e_cnt = W'(cyc - m_last); e_mv = 1'b1; e_to = 1'b0;
            hist.push_back(cyc - m_last); m_last = cyc; e_lk = lock_ok();
          end else if (cyc - m_last == TIMEOUT) begin
            e_to = 1'b1; e_lk = 1'b0; m_run = 1'b0; hist.delete();
          end
        end else if (qual) begin
          m_run = 1'b1; m_last = cyc;
        end
        m_fm = fm_s;
      end
      check("cycle", 64'({bus.meas_valid, bus.locked, bus.timeout, bus.cnt_out}),
                     64'({e_mv, e_lk, e_to, e_cnt}));
      if (bus.meas_valid) mv_count++;
      if (bus.locked) lk_seen = 1'b1;
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sig(input bit v);
    if (v != sig_level) ev_q.push_back('{due: cyc + 3, rising: v});
    sig_level  = v;
    bus.sig_in = v;
    last_tog   = cyc;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; bus.sig_in = 1'b0; sig_level = 1'b0;
    tick(n);
    reset = 1'b1;
  endtask

  task automatic toggles(input int half, input int n);
    for (int i = 0; i < n; i++) begin
      tick(half);
      set_sig(~sig_level);
    end
  endtask

  typedef struct {int half; bit fm; int n; int exp_cnt; bit exp_lk; bit exp_to;} vec_t;
  vec_t vecs[9];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int mv0, tc, p, len;
    bit got;

    vecs[0] = '{5, 1'b0, 4, 5, 1'b0, 1'b0};
    vecs[1] = '{5, 1'b0, 5, 5, 1'b1, 1'b0};
    vecs[2] = '{5, 1'b1, 9, 10, 1'b1, 1'b0};
    vecs[3] = '{5, 1'b1, 7, 10, 1'b0, 1'b0};
    vecs[4] = '{7, 1'b0, 6, 7, 1'b1, 1'b0};
    vecs[5] = '{1, 1'b0, 6, 1, 1'b1, 1'b0};
    vecs[6] = '{32, 1'b1, 9, 64, 1'b1, 1'b0};
    vecs[7] = '{33, 1'b0, 3, 33, 1'b0, 1'b0};
    vecs[8] = '{40, 1'b1, 5, 0, 1'b0, 1'b1};

    bus.sig_in = 1'b0;
    bus.full_mode = 1'b0;

    // Reset held 5 cycles, then static input: nothing may happen.
    tick(5);
    reset = 1'b1;
    tick(100);
    @(negedge clk);
    check("idle_no_meas", 64'(mv_count), 64'd0);
    check("idle_outputs", 64'({bus.meas_valid, bus.locked, bus.timeout, bus.cnt_out}), 64'd0);
    $display("reset/idle: cnt_out=%0d meas pulses=%0d", bus.cnt_out, mv_count);

    // Table-driven rows.
    for (int r = 0; r < 9; r++) begin
      bus.full_mode = vecs[r].fm;
      do_reset(3);
      toggles(vecs[r].half, vecs[r].n);
      tick(4);
      @(negedge clk);
      check($sformatf("row%0d", r), 64'({bus.cnt_out, bus.locked, bus.timeout}),
            64'({W'(vecs[r].exp_cnt), vecs[r].exp_lk, vecs[r].exp_to}));
      $display("row %0d half=%0d fm=%0d n=%0d: cnt_out=%0d locked=%0b timeout=%0b",
               r, vecs[r].half, vecs[r].fm, vecs[r].n, bus.cnt_out, bus.locked, bus.timeout);
    end

    // Latency: pulse appears exactly three clk edges after the second toggle.
    bus.full_mode = 1'b0;
    do_reset(3);
    toggles(5, 2);
    tick(2);
    @(negedge clk);
    check("latency_early", 64'(bus.meas_valid), 64'd0);
    tick(1);
    @(negedge clk);
    check("latency_pulse", 64'({bus.meas_valid, bus.cnt_out}), 64'({1'b1, W'(5)}));
    $display("latency: meas_valid at toggle+3, cnt_out=%0d", bus.cnt_out);

    // Full mode lock, then switch mode: lock drops one cycle later.
    bus.full_mode = 1'b1;
    do_reset(3);
    toggles(5, 9);
    tick(4);
    @(negedge clk);
    check("full_lock", 64'({bus.locked, bus.cnt_out}), 64'({1'b1, W'(10)}));
    tick(1);
    bus.full_mode = 1'b0;
    @(negedge clk);
    check("mode_lock_hold", 64'(bus.locked), 64'd1);
    @(negedge clk);
    check("mode_lock_drop", 64'(bus.locked), 64'd0);
    mv0 = mv_count;
    toggles(5, 2);
    tick(4);
    @(negedge clk);
    check("mode_restart", 64'({32'(mv_count - mv0), bus.cnt_out}), 64'({32'd1, W'(5)}));
    $display("mode switch: locked=%0b cnt_out=%0d", bus.locked, bus.cnt_out);

    // Timeout after a locked run, then recovery at period 7.
    do_reset(3);
    toggles(5, 6);
    got = 1'b0; tc = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.timeout) begin got = 1'b1; tc = cyc; end
    end
    check("timeout_seen", 64'(got), 64'd1);
    check("timeout_cycle", 64'(tc), 64'(last_tog + 3 + TIMEOUT));
    check("timeout_state", 64'({bus.locked, bus.cnt_out}), 64'({1'b0, W'(5)}));
    tick(1);
    toggles(7, 1);
    tick(6);
    @(negedge clk);
    check("timeout_sticky", 64'(bus.timeout), 64'd1);
    tick(1);
    set_sig(~sig_level);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.meas_valid) got = 1'b1;
    end
    check("recover_pulse", 64'(got), 64'd1);
    check("recover_value", 64'({bus.timeout, bus.cnt_out}), 64'({1'b0, W'(7)}));
    $display("timeout: set at cycle %0d, recovered cnt_out=%0d", tc, bus.cnt_out);

    // Alternating 5/6 periods never lock.
    do_reset(3);
    lk_seen = 1'b0;
    mv0 = mv_count;
    for (int i = 0; i < 12; i++) toggles((i % 2 == 0) ? 5 : 6, 1);
    tick(4);
    @(negedge clk);
    check("alt_pulses", 64'(mv_count - mv0), 64'd11);
    check("alt_nolock", 64'(lk_seen), 64'd0);
    $display("alternating: pulses=%0d locked_seen=%0b", mv_count - mv0, lk_seen);

    // Reset at run count 3 while locked.
    do_reset(3);
    toggles(5, 6);
    tick(4);
    @(negedge clk);
    check("pre_reset_lock", 64'(bus.locked), 64'd1);
    tick(1);
    reset = 1'b0; bus.sig_in = 1'b0; sig_level = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_reset_outputs", 64'({bus.meas_valid, bus.locked, bus.timeout, bus.cnt_out}), 64'd0);
    tick(3);
    reset = 1'b1;
    mv0 = mv_count;
    toggles(5, 1);
    tick(5);
    @(negedge clk);
    check("post_reset_one_edge", 64'(mv_count - mv0), 64'd0);
    toggles(1, 1);
    tick(4);
    @(negedge clk);
    check("post_reset_two_edges", 64'({32'(mv_count - mv0), bus.cnt_out}), 64'({32'd1, W'(6)}));
    $display("mid reset: after two edges cnt_out=%0d", bus.cnt_out);

    // Randomized bursts, checked by the per-cycle model.
    bus.full_mode = 1'b0;
    do_reset(3);
    for (int b = 0; b < 60; b++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.full_mode = ~bus.full_mode;
        tick($urandom_range(1, 3));
      end
      if ($urandom_range(0, 9) == 0) begin
        p = $urandom_range(60, 75); len = $urandom_range(1, 2);
      end else begin
        p = $urandom_range(1, 12); len = $urandom_range(1, 8);
      end
      toggles(p, len);
    end
    tick(8);
    $display("random: %0d meas pulses observed", mv_count);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
